// File: rtl/btb_update_unit.sv
// rtl/btb_update_unit.sv - BTB writer: mispredict detection plus coalescing update queue
//
// Purpose:
//   Takes resolved branches from execute and reports mispredictions one cycle
//   later with the correct next PC. Taken branches are buffered in a small
//   queue that coalesces repeated PCs, and the queue drains onto the BTB write
//   port at one entry per cycle.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   resolve_*            resolved branch (valid, pc, target, taken, hit, pred_target)
//   hold                 suppress the BTB write this cycle
//   load/w_pc/target_in  BTB write port (head of queue)
//   mispredict           registered mispredict pulse
//   redirect_pc          correct next PC, valid with mispredict
//   q_full/q_count       queue status
//   drop_cnt             saturating count of updates lost to a full queue
//
// Build option:
//   BTB_UPDATE_FILTER_EN - when defined, a taken branch that hit with the
//   correct predicted target is not enqueued (the BTB already holds it).

module btb_update_unit #(
  parameter int width    = 32,
  parameter int depth    = 4,
  parameter int ptr_bits = $clog2(depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resolve_valid,
  input  logic [width-1:0]    resolve_pc,
  input  logic [width-1:0]    resolve_target,
  input  logic                resolve_taken,
  input  logic                resolve_hit,
  input  logic [width-1:0]    resolve_pred_target,
  input  logic                hold,
  output logic                load,
  output logic [width-1:0]    w_pc,
  output logic [width-1:0]    target_in,
  output logic                mispredict,
  output logic [width-1:0]    redirect_pc,
  output logic                q_full,
  output logic [ptr_bits:0]   q_count,
  output logic [7:0]          drop_cnt
);

  localparam logic [ptr_bits:0] full_count = (ptr_bits+1)'(depth);

  logic [width-1:0]    q_pc  [depth];
  logic [width-1:0]    q_tgt [depth];
  logic [ptr_bits-1:0] head;
  logic [ptr_bits-1:0] tail;
  logic [ptr_bits:0]   count;

  logic                deq;
  logic                cand;
  logic                coalesce;
  logic                append;
  logic                drop;
  logic                mp_now;
  logic [ptr_bits-1:0] match_idx;
  logic [ptr_bits-1:0] offset;

  always_comb begin
    deq = (count != '0) && !hold;

`ifdef BTB_UPDATE_FILTER_EN
    cand = resolve_valid && resolve_taken &&
           !(resolve_hit && (resolve_pred_target == resolve_target));
`else
    cand = resolve_valid && resolve_taken;
`endif

    // Search occupied slots for the same PC. The head that pops this cycle is
    // excluded so the update is appended rather than lost with the popped entry.
    coalesce  = 1'b0;
    match_idx = '0;
    offset    = '0;
    for (int i = 0; i < depth; i++) begin
      offset = ptr_bits'(i) - head;
      if (({1'b0, offset} < count) && (q_pc[i] == resolve_pc) &&
          !(deq && (ptr_bits'(i) == head))) begin
        coalesce  = cand;
        match_idx = ptr_bits'(i);
      end
    end

    // A full queue still accepts an append when the head pops in the same cycle.
    append = cand && !coalesce && ((count != full_count) || deq);
    drop   = cand && !coalesce && !append;

    mp_now = resolve_valid &&
             ((resolve_taken && (!resolve_hit || (resolve_pred_target != resolve_target))) ||
              (!resolve_taken && resolve_hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (coalesce) begin
        q_tgt[match_idx] <= resolve_target;
      end
      if (append) begin
        q_pc[tail]  <= resolve_pc;
        q_tgt[tail] <= resolve_target;
        tail        <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({append, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 8'hff)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      mispredict <= mp_now;
      if (mp_now) begin
        redirect_pc <= resolve_taken ? resolve_target : resolve_pc + width'(4);
      end
    end
  end

  // Gate on rst so nothing reaches the BTB in the reset cycle.
  assign load      = deq && !rst;
  assign q_full    = (count == full_count);
  assign q_count   = count;
  assign w_pc      = (count != '0) ? q_pc[head]  : '0;
  assign target_in = (count != '0) ? q_tgt[head] : '0;

endmodule

// File: tb/tb_btb_update_unit.sv
// tb/tb_btb_update_unit.sv - self-checking bench for btb_update_unit

module tb_btb_update_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv;
  logic [31:0] pc;
  logic [31:0] tg;
  logic        tk;
  logic        hit;
  logic [31:0] pt;
  logic        hold;

  logic        load;
  logic [31:0] w_pc;
  logic [31:0] target_in;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        q_full;
  logic [2:0]  q_count;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  btb_update_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .resolve_valid       (rv),
    .resolve_pc          (pc),
    .resolve_target      (tg),
    .resolve_taken       (tk),
    .resolve_hit         (hit),
    .resolve_pred_target (pt),
    .hold                (hold),
    .load                (load),
    .w_pc                (w_pc),
    .target_in           (target_in),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc),
    .q_full              (q_full),
    .q_count             (q_count),
    .drop_cnt            (drop_cnt)
  );

  // Reference model: a plain list of pending {pc, target} updates.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
  } ent_t;

  ent_t        mq[$];
  logic        m_mis  = 1'b0;
  logic [31:0] m_red  = '0;
  int          m_drop = 0;

  always @(posedge clk) begin
    bit pop;
    bit cand;
    bit merged;
    bit room;
    if (rst) begin
      mq.delete();
      m_mis  = 1'b0;
      m_red  = '0;
      m_drop = 0;
    end else begin
      pop = (mq.size() != 0) && !hold;
      if (rv && ((tk && !hit) || (tk && hit && pt != tg) || (!tk && hit))) begin
        m_mis = 1'b1;
        m_red = tk ? tg : pc + 32'd4;
      end else begin
        m_mis = 1'b0;
      end
`ifdef BTB_UPDATE_FILTER_EN
      cand = rv && tk && !(hit && pt == tg);
`else
      cand = rv && tk;
`endif
      merged = 1'b0;
      if (cand) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!(pop && i == 0) && mq[i].pc == pc) begin
            mq[i].tg = tg;
            merged   = 1'b1;
          end
        end
      end
      room = (mq.size() < 4) || pop;
      if (pop) void'(mq.pop_front());
      if (cand && !merged) begin
        if (room) mq.push_back('{pc: pc, tg: tg});
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model load",        32'(load),        32'((mq.size() != 0) && !hold && !rst));
      check("model w_pc",        w_pc,             (mq.size() != 0) ? mq[0].pc : 32'h0);
      check("model target_in",   target_in,        (mq.size() != 0) ? mq[0].tg : 32'h0);
      check("model q_count",     32'(q_count),     32'(mq.size()));
      check("model q_full",      32'(q_full),      32'(mq.size() == 4));
      check("model mispredict",  32'(mispredict),  32'(m_mis));
      check("model redirect_pc", redirect_pc,      m_red);
      check("model drop_cnt",    32'(drop_cnt),    32'(m_drop));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic br(input logic [31:0] p, input logic [31:0] t, input logic taken,
                    input logic h, input logic [31:0] ptg);
    rv = 1'b1; pc = p; tg = t; tk = taken; hit = h; pt = ptg;
  endtask

  task automatic idle();
    rv = 1'b0; pc = '0; tg = '0; tk = 1'b0; hit = 1'b0; pt = '0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset load", 32'(load), 32'h0);
    check("reset q_count", 32'(q_count), 32'h0);
    check("reset mispredict", 32'(mispredict), 32'h0);
    check("reset w_pc", w_pc, 32'h0);

    // Taken miss: mispredict and one queued write
    cyc();
    br(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    check("t1 mispredict", 32'(mispredict), 32'h1);
    check("t1 redirect", redirect_pc, 32'h200);
    check("t1 q_count", 32'(q_count), 32'h1);
    check("t1 load", 32'(load), 32'h1);
    check("t1 w_pc", w_pc, 32'h100);
    check("t1 target_in", target_in, 32'h200);
    cyc();
    @(negedge clk);
    check("t1 drained count", 32'(q_count), 32'h0);
    check("t1 drained load", 32'(load), 32'h0);
    check("t1 redirect hold", redirect_pc, 32'h200);

    // Not-taken but predicted taken
    cyc();
    br(32'h40, 32'h80, 1'b0, 1'b1, 32'h80);
    cyc();
    idle();
    @(negedge clk);
    check("t2 mispredict", 32'(mispredict), 32'h1);
    check("t2 redirect", redirect_pc, 32'h44);
    check("t2 q_count", 32'(q_count), 32'h0);

    // Fill under hold, drop one, drain in order
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      br(32'(k * 16), 32'(k * 16) + 32'h1000, 1'b1, 1'b0, 32'h0);
      cyc();
    end
    idle();
    @(negedge clk);
    check("t3 q_full", 32'(q_full), 32'h1);
    cyc();
    br(32'h50, 32'h1050, 1'b1, 1'b0, 32'h0);
    cyc();
    idle();
    hold = 1'b0;
    @(negedge clk);
    check("t3 drop_cnt", 32'(drop_cnt), 32'h1);
    check("t3 q_count", 32'(q_count), 32'h4);
    for (int k = 1; k <= 4; k++) begin
      check("t3 drain load", 32'(load), 32'h1);
      check("t3 drain w_pc", w_pc, 32'(k * 16));
      cyc();
      @(negedge clk);
    end
    check("t3 empty", 32'(q_count), 32'h0);

    // Coalesce two updates to the same PC
    cyc();
    hold = 1'b1;
    br(32'h80, 32'h900, 1'b1, 1'b0, 32'h0);
    cyc();
    br(32'h80, 32'hA00, 1'b1, 1'b0, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    check("t4 q_count", 32'(q_count), 32'h1);
    cyc();
    hold = 1'b0;
    @(negedge clk);
    check("t4 load", 32'(load), 32'h1);
    check("t4 target_in", target_in, 32'hA00);
    cyc();
    @(negedge clk);
    check("t4 empty", 32'(q_count), 32'h0);

    // Full queue accepts an append while popping
    cyc();
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      br(32'h100 + 32'(k * 16), 32'h2000 + 32'(k), 1'b1, 1'b0, 32'h0);
      cyc();
    end
    hold = 1'b0;
    br(32'h60, 32'h2060, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t5 head", w_pc, 32'h110);
    cyc();
    idle();
    @(negedge clk);
    check("t5 q_count", 32'(q_count), 32'h4);
    check("t5 drop_cnt", 32'(drop_cnt), 32'h1);
    check("t5 w_pc0", w_pc, 32'h120);
    cyc();
    @(negedge clk);
    check("t5 w_pc1", w_pc, 32'h130);
    cyc();
    @(negedge clk);
    check("t5 w_pc2", w_pc, 32'h140);
    cyc();
    @(negedge clk);
    check("t5 w_pc3", w_pc, 32'h60);
    check("t5 tgt3", target_in, 32'h2060);
    cyc();
    @(negedge clk);
    check("t5 empty", 32'(q_count), 32'h0);

    // Same PC as the popping head appends instead of coalescing
    cyc();
    hold = 1'b1;
    br(32'h200, 32'h500, 1'b1, 1'b0, 32'h0);
    cyc();
    hold = 1'b0;
    br(32'h200, 32'h777, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t6 old target", target_in, 32'h500);
    cyc();
    idle();
    @(negedge clk);
    check("t6 q_count", 32'(q_count), 32'h1);
    check("t6 new target", target_in, 32'h777);
    cyc();
    @(negedge clk);
    check("t6 empty", 32'(q_count), 32'h0);

    // Correctly predicted taken branch
    cyc();
    hold = 1'b1;
    br(32'h180, 32'h300, 1'b1, 1'b1, 32'h300);
    cyc();
    idle();
    @(negedge clk);
    check("t7 mispredict", 32'(mispredict), 32'h0);
`ifdef BTB_UPDATE_FILTER_EN
    check("t7 q_count", 32'(q_count), 32'h0);
`else
    check("t7 q_count", 32'(q_count), 32'h1);
`endif
    cyc();
    hold = 1'b0;
    cyc();

    // drop_cnt saturation
    hold = 1'b1;
    for (int i = 0; i < 260; i++) begin
      br(32'h1000 + 32'(i * 4), 32'h3000, 1'b1, 1'b0, 32'h0);
      cyc();
    end
    idle();
    @(negedge clk);
    check("t8 drop_cnt sat", 32'(drop_cnt), 32'hff);
    check("t8 q_full", 32'(q_full), 32'h1);

    // Reset mid-operation discards the queue
    cyc();
    hold = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t9 no write in reset", 32'(load), 32'h0);
    cyc();
    rst = 1'b0;
    hold = 1'b1;
    @(negedge clk);
    check("t9 q_count", 32'(q_count), 32'h0);
    check("t9 drop_cnt", 32'(drop_cnt), 32'h0);
    check("t9 redirect", redirect_pc, 32'h0);
    check("t9 q_full", 32'(q_full), 32'h0);
    cyc();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
